// File: rtl/mult_controller.sv
// Sequencing FSM for the WIDTH x WIDTH shift-add multiplier datapath.
// Optional feature macro: MULT_CTRL_DONE_HOLD_EN (done held until ack).
module mult_controller #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  input  logic          b_lsb,
  output logic          ld_a,
  output logic          ld_b,
  output logic          clr_p,
  output logic          ld_p,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    strobe_q, strobe_d;

  // Strobe vector layout: {ld_a, ld_b, clr_p, ld_p, shift, busy, done}
  function automatic logic [6:0] decode_strobes(input state_t s);
    logic [6:0] v;
    v = 7'b000_0000;
    case (s)
      IDLE:    v = 7'b000_0000;
      LOAD:    v = 7'b111_0010;
      TEST:    v = 7'b000_0010;
      ADD:     v = 7'b000_1010;
      SHIFT:   v = 7'b000_0110;
      DONE:    v = 7'b000_0011;
      default: v = 7'b000_0000;
    endcase
    return v;
  endfunction

  // Next-state, iteration counter and strobe decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = TEST;
      end
      TEST: begin
        if (b_lsb) begin
          state_d = ADD;
        end else begin
          state_d = SHIFT;
        end
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        // Last increment suppressed so cnt never wraps
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = TEST;
        end
      end
      DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
        if (ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Strobes decoded from the upcoming state so registered outputs track state
    strobe_d = decode_strobes(state_d);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      strobe_q <= 7'b000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign {ld_a, ld_b, clr_p, ld_p, shift, busy, done} = strobe_q;
  assign cnt = cnt_q;

`ifndef MULT_CTRL_DONE_HOLD_EN
  logic unused_ack_s;
  assign unused_ack_s = ack;
`endif

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller with a behavioural shift-add datapath.
module tb_mult_controller;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH);

  logic          clk, rst, start, ack, b_lsb;
  logic          ld_a, ld_b, clr_p, ld_p, shift, busy, done;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  logic [3:0] op_a, op_b;
  logic [7:0] mc, acc;
  logic [3:0] mp;
  logic [8:0] outs;

  mult_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .b_lsb(b_lsb),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .ld_p(ld_p), .shift(shift),
    .busy(busy), .done(done), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs  = {ld_a, ld_b, clr_p, ld_p, shift, busy, done, cnt};
  assign b_lsb = mp[0];

  // Datapath driven by the controller strobes
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc <= 8'h00; mp <= 4'h0; acc <= 8'h00;
    end else begin
      if (ld_a)  mc  <= {4'h0, op_a};
      if (ld_b)  mp  <= op_b;
      if (clr_p) acc <= 8'h00;
      if (ld_p)  acc <= acc + mc;
      if (shift) begin
        mc <= mc << 1;
        mp <= mp >> 1;
      end
    end
  end

  task automatic drain;
    int n;
    n = 0;
    ack = 1'b1;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk);
  endtask

  task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input bit toggle,
                         input bit hold_start, input int ack_delay);
    int c, n_load, n_ldp, n_shift, n_bad, n_badcnt, n_nobusy, done_cyc, n_hold, exp_cyc;
    logic [3:0] ldp_mask;
    logic [7:0] exp_p;
    n_load = 0; n_ldp = 0; n_shift = 0; n_bad = 0; n_badcnt = 0; n_nobusy = 0;
    done_cyc = 0; ldp_mask = 4'h0;
    exp_cyc = 2 + 2 * WIDTH + $countones(b);
    exp_p   = 8'(a) * 8'(b);
    op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b1;
    for (c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (!hold_start) start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ld_a || ld_b || clr_p) begin
        n_load++;
        if (c != 1 || !(ld_a && ld_b && clr_p)) n_bad++;
      end
      if (ld_p && shift) n_bad++;
      if (ld_p) begin
        n_ldp++;
        ldp_mask[cnt] = 1'b1;
      end
      if (shift) begin
        if (cnt !== CW'(n_shift)) n_badcnt++;
        n_shift++;
      end
      if (busy !== 1'b1) n_nobusy++;
      if (done === 1'b1) done_cyc = c;
      else ack = 1'($urandom_range(0, 1));
    end
    if (!hold_start) start = 1'b0;
    checks++;
    if (done_cyc != exp_cyc) begin
      failures++;
      $display("FAIL done_cycle: got %0d required %0d (b=%h)", done_cyc, exp_cyc, b);
    end
    checks++;
    if (acc !== exp_p) begin
      failures++;
      $display("FAIL product: got %h required %h (a=%h b=%h)", acc, exp_p, a, b);
    end
    checks++;
    if (n_load != 1 || n_bad != 0) begin
      failures++;
      $display("FAIL strobe_rules: loads=%0d bad=%0d required loads=1 bad=0", n_load, n_bad);
    end
    checks++;
    if (n_ldp != $countones(b) || ldp_mask !== b) begin
      failures++;
      $display("FAIL ld_p_pattern: count=%0d mask=%b required count=%0d mask=%b",
               n_ldp, ldp_mask, $countones(b), b);
    end
    checks++;
    if (n_shift != WIDTH || n_badcnt != 0) begin
      failures++;
      $display("FAIL shift_cnt: shifts=%0d badcnt=%0d required %0d and 0", n_shift, n_badcnt, WIDTH);
    end
    checks++;
    if (n_nobusy != 0) begin
      failures++;
      $display("FAIL busy_during_op: low cycles=%0d required 0", n_nobusy);
    end
`ifdef MULT_CTRL_DONE_HOLD_EN
    n_hold = 1;
    ack = (ack_delay == 0);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_hold++;
      ack = (i == ack_delay - 1);
    end
    checks++;
    if (n_hold != ack_delay + 1) begin
      failures++;
      $display("FAIL done_hold_len: got %0d required %0d", n_hold, ack_delay + 1);
    end
`else
    n_hold = 1;
    ack = (ack_delay > 0) ? 1'b1 : 1'($urandom_range(0, 1));
`endif
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL return_idle: done=%0b busy=%0b required 0 0 (hold=%0d)", done, busy, n_hold);
    end
    if (hold_start) begin
      @(negedge clk);
      checks++;
      if ({ld_a, ld_b, clr_p, busy} !== 4'b1111) begin
        failures++;
        $display("FAIL back_to_back_load: got %b required 1111", {ld_a, ld_b, clr_p, busy});
      end
      start = 1'b0;
      drain();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; ack = 1'b0; op_a = 4'h0; op_b = 4'h0;
    #1;
    checks++;
    if (outs !== 9'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0", outs);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 9'h000) begin
      failures++;
      $display("FAIL reset_hold_start: got %b required 0", outs);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 9'h000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b required 0", outs);
    end
  endtask

  task automatic test_reset_mid;
    op_a = 4'h3; op_b = 4'hF;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ld_p !== 1'b1) begin
      failures++;
      $display("FAIL mid_add_reach: ld_p=%0b required 1", ld_p);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs !== 9'h000) begin
      failures++;
      $display("FAIL async_reset: got %b required 0", outs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ld_a, ld_b, clr_p, busy, cnt} !== {4'b1111, CW'(0)}) begin
      failures++;
      $display("FAIL load_after_release: got %b required %b", {ld_a, ld_b, clr_p, busy, cnt},
               {4'b1111, CW'(0)});
    end
    start = 1'b0;
    drain();
  endtask

  task automatic test_zero_multiplier;
    do_mult(4'b1011, 4'b0000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_all_ones;
    do_mult(4'b1111, 4'b1111, 1'b0, 1'b0, 1);
  endtask

  task automatic test_sparse;
    do_mult(4'b0011, 4'b0101, 1'b0, 1'b0, 2);
  endtask

  task automatic test_start_toggle;
    do_mult(4'($urandom_range(0, 15)), 4'b1001, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    do_mult(4'b0110, 4'b1010, 1'b0, 1'b1, 0);
  endtask

  task automatic test_done_ack;
    do_mult(4'b0111, 4'b0011, 1'b0, 1'b0, 5);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      do_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0,
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_zero_multiplier();
    test_all_ones();
    test_sparse();
    test_start_toggle();
    test_back_to_back();
    test_done_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_controller.md
# mult_controller

Sequencing FSM for the 4x4 shift-add multiplier datapath. It accepts a start request, loads the operand registers, and clears the product register. It then steps once per multiplier bit, issuing add/load and shift strobes to the 8-bit registers and shifter, and reports completion with a done handshake. It sits between the top-level wrapper and the datapath registers, which all share its clock and reset.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; iteration count per multiply
- CW, $clog2(WIDTH), iteration counter width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- start  input  1  multiply request, sampled only in IDLE
- ack  input  1  completion acknowledge (used only with MULT_CTRL_DONE_HOLD_EN)
- b_lsb  input  1  current LSB of the multiplier register, from the datapath
- ld_a  output  1  load multiplicand register
- ld_b  output  1  load multiplier register
- clr_p  output  1  clear product register
- ld_p  output  1  load product register with partial sum
- shift  output  1  shift product/multiplier one bit right
- busy  output  1  high in every state except IDLE
- done  output  1  result valid in product register
- cnt  output  CW  iteration index, 0..WIDTH-1

## Operation
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Encoding is free.
- IDLE: all strobes 0, busy=0. start=1 -> LOAD. Otherwise stay.
- LOAD: ld_a=ld_b=clr_p=1 for exactly one cycle; cnt<=0; -> TEST.
- TEST: no strobes. b_lsb=1 -> ADD, b_lsb=0 -> SHIFT.
- ADD: ld_p=1 for one cycle -> SHIFT.
- SHIFT: shift=1 for one cycle. If cnt==WIDTH-1 -> DONE; else cnt<=cnt+1 and -> TEST.
- DONE: done=1, busy=1. Exit behaviour depends on configuration.
- Strobes are Moore outputs decoded from state only. ld_p and shift are never high together. ld_a, ld_b, and clr_p are high only in LOAD.
- start is ignored in every state except IDLE. No queuing.
- cnt holds its value outside LOAD and SHIFT. It does not wrap, because the last increment is suppressed at WIDTH-1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, and every output is 0. Reset takes effect mid-operation in any state, and the in-flight multiply is discarded. The first start is accepted on the first rising edge where rst=1.
- start is sampled at edge E0; LOAD occupies the cycle after E0.
- Each bit takes 2 cycles (TEST, SHIFT), or 3 cycles when b_lsb=1 (TEST, ADD, SHIFT).
- done first asserts 2 + 2*WIDTH + k cycles after E0, where k = number of 1 bits in the multiplier. For WIDTH=4 this is 10 to 14 cycles.
- b_lsb is sampled only at the TEST->next edge. The datapath must present the shifted LSB by the cycle after SHIFT.
- Simultaneous start and done (pulse mode): the controller is in IDLE only on the cycle after DONE, so back-to-back start is accepted then. The minimum issue interval is 2 + 2*WIDTH + k + 1 cycles.

## Configuration
- MULT_CTRL_DONE_HOLD_EN defined:
  - DONE holds done=1 until ack=1 is sampled, then -> IDLE.
  - ack=1 in the same cycle done first rises is accepted, giving a one-cycle done.
  - ack outside DONE is ignored.
- Undefined:
  - done is a single-cycle pulse and DONE -> IDLE unconditionally.
  - ack is ignored entirely.

## Test plan
- Reset: drive rst=0 mid-ADD with start held 1 -> all outputs 0 and cnt=0 immediately (asynchronously). Release -> LOAD on the next edge.
- Multiplier 4'b0000, multiplicand 4'b1011: start pulse -> ld_a/ld_b/clr_p high 1 cycle, zero ld_p pulses, 4 shift pulses, done at cycle 10 after E0; product 8'h00.
- Multiplier 4'b1111, multiplicand 4'b1111: 4 ld_p and 4 shift pulses, alternating and never overlapping; done at cycle 14; product 8'hE1.
- Multiplier 4'b0101, multiplicand 4'b0011: ld_p only in iterations cnt=0 and cnt=2; done at cycle 12; product 8'h0F.
- start toggled while busy=1: no extra LOAD and cnt sequence unaffected. start held high through done: new multiply begins the cycle after IDLE is re-entered.
- With MULT_CTRL_DONE_HOLD_EN, ack low for 5 cycles: done stays 1 for 5 cycles plus the ack cycle, then IDLE. Without the macro: done is high exactly 1 cycle regardless of ack.
